// File: rtl/adc_stream_pkg.sv
// Shared types and constants for the ADC stream scheduler: FSM state enum,
// default frame header byte and the active-low one-hot LED encoding.
package adc_stream_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARM       = 3'd1,
    ST_CAPTURE   = 3'd2,
    ST_SEND_HDR  = 3'd3,
    ST_SEND_DATA = 3'd4,
    ST_DONE      = 3'd5
  } state_t;

  localparam logic [7:0] HEADER_DEFAULT = 8'hAA;

  localparam logic [5:0] LED_IDLE      = 6'b111110;
  localparam logic [5:0] LED_ARM       = 6'b111101;
  localparam logic [5:0] LED_CAPTURE   = 6'b111011;
  localparam logic [5:0] LED_SEND_HDR  = 6'b110111;
  localparam logic [5:0] LED_SEND_DATA = 6'b101111;
  localparam logic [5:0] LED_DONE      = 6'b011111;

  function automatic logic [5:0] led_code(input state_t s);
    logic [5:0] code;
    code = '1;
    case (s)
      ST_IDLE:      code = LED_IDLE;
      ST_ARM:       code = LED_ARM;
      ST_CAPTURE:   code = LED_CAPTURE;
      ST_SEND_HDR:  code = LED_SEND_HDR;
      ST_SEND_DATA: code = LED_SEND_DATA;
      ST_DONE:      code = LED_DONE;
      default:      code = '1;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/adc_stream_scheduler_sample_buffer.sv
// sample_buffer: simple dual-port RAM, one synchronous write port and one
// asynchronous read port so read data is valid in the addressed cycle.
module sample_buffer #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 64,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/adc_stream_scheduler.sv
// Captures DEPTH ADC samples at one per SAMPLE_DIV clocks, then streams a
// HEADER byte plus the samples over a valid/ready byte interface.
// Optional rising-edge trigger in ARM: define ADC_STREAM_TRIGGER_EN.
module adc_stream_scheduler
  import adc_stream_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = 3744,
  parameter int unsigned DEPTH      = 64,
  parameter logic [7:0]  HEADER     = HEADER_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] adc_in,
  input  logic [7:0] trig_level,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic [5:0] led
);

  localparam int unsigned   AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned   DW       = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);
  localparam logic [AW-1:0] IDX_LAST = AW'(DEPTH - 1);

  logic [1:0]    rst_sync;
  logic          rst_int_n;
  state_t        state;
  logic [DW-1:0] div;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic [7:0]    prev_sample;
  logic [7:0]    rd_data;
  logic          strobe;
  logic          trig_ok;
  logic          wr_en;
  logic          hs;

  // Assert asynchronously, release two clocks after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  assign strobe = ((state == ST_ARM) || (state == ST_CAPTURE)) && (div == DIV_LAST);

`ifdef ADC_STREAM_TRIGGER_EN
  assign trig_ok = (prev_sample < trig_level) && (adc_in >= trig_level);
`else
  logic unused_trig;
  assign trig_ok     = 1'b1;
  assign unused_trig = ^{trig_level, prev_sample};
`endif

  assign wr_en    = strobe && ((state == ST_CAPTURE) || trig_ok);
  assign tx_valid = (state == ST_SEND_HDR) || (state == ST_SEND_DATA);
  assign hs       = tx_valid && tx_ready;
  assign busy     = (state != ST_IDLE);
  assign led      = led_code(state);

  always_comb begin
    tx_data = '0;
    if (state == ST_SEND_HDR)       tx_data = HEADER;
    else if (state == ST_SEND_DATA) tx_data = rd_data;
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state       <= ST_IDLE;
      div         <= '0;
      wr_idx      <= '0;
      rd_idx      <= '0;
      prev_sample <= '0;
    end else begin
      if ((state == ST_ARM) || (state == ST_CAPTURE))
        div <= (div == DIV_LAST) ? '0 : div + DW'(1);
      else
        div <= '0;

      if (strobe) prev_sample <= adc_in;

      case (state)
        ST_IDLE: if (start) begin
          state  <= ST_ARM;
          wr_idx <= '0;
          // Max value means no level present at arm can count as a crossing.
          prev_sample <= '1;
        end
        ST_ARM: if (wr_en) begin
          state  <= ST_CAPTURE;
          wr_idx <= AW'(1);
        end
        ST_CAPTURE: if (strobe) begin
          if (wr_idx == IDX_LAST) begin
            state  <= ST_SEND_HDR;
            wr_idx <= '0;
          end else begin
            wr_idx <= wr_idx + AW'(1);
          end
        end
        ST_SEND_HDR: if (hs) begin
          state  <= ST_SEND_DATA;
          rd_idx <= '0;
        end
        ST_SEND_DATA: if (hs) begin
          if (rd_idx == IDX_LAST) begin
            state  <= ST_DONE;
            rd_idx <= '0;
          end else begin
            rd_idx <= rd_idx + AW'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  sample_buffer #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_idx),
    .wr_data (adc_in),
    .rd_addr (rd_idx),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_adc_stream_scheduler.sv
// Randomized self-checking bench for adc_stream_scheduler against a
// frame-level model: strobe sample list, trigger search, expected byte list.
module tb_adc_stream_scheduler;

  localparam int unsigned SD     = 4;
  localparam int unsigned DP     = 8;
  localparam logic [7:0]  HDR    = 8'hAA;
  localparam int          BUDGET = 800;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] adc_in;
  logic [7:0] trig_level;
  logic       tx_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       busy;
  logic [5:0] led;

  int n_checks;
  int n_errors;
  logic [7:0] first_data;

  adc_stream_scheduler #(
    .SAMPLE_DIV (SD),
    .DEPTH      (DP),
    .HEADER     (HDR)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .adc_in     (adc_in),
    .trig_level (trig_level),
    .tx_ready   (tx_ready),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .busy       (busy),
    .led        (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] adc_value(input int mode, input int cyc);
    int s;
    s = (cyc - 1) / int'(SD);
    case (mode)
      0: return 8'(s);
      1: return 8'($urandom);
      2: begin
        if (s == 0) return 8'h70;
        if (s == 1) return 8'h7F;
        return 8'(32'h85 + s - 2);
      end
      default: begin
        if (s == 0) return 8'h90;
        if (s == 1) return 8'h95;
        if (s == 2) return 8'h10;
        return 8'(32'h88 + s - 3);
      end
    endcase
  endfunction

  // adc_mode: 0 ramp per strobe, 1 random per cycle, 2/3 trigger sequences.
  // rdy_mode: 0 always ready, 1 ready one cycle in three, 2 random.
  task automatic run_frame(input int adc_mode, input int rdy_mode,
                           input bit stray_start, input bit abort);
    logic [7:0] strobes[$];
    logic [7:0] got[$];
    logic       stalled;
    logic [7:0] stall_data;
    int         done_at;
    int         t;
    int         idx;
    bit         finished;
    logic [31:0] exp;

    stalled  = 1'b0;
    done_at  = -10;
    finished = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= BUDGET; cyc++) begin
      adc_in = adc_value(adc_mode, cyc);
      case (rdy_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = (cyc % 3 == 0);
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      start = stray_start && ((cyc == 3 * int'(SD) + 2) || (cyc == done_at + 1));
      @(negedge clk);
      if (abort && got.size() == 4 && tx_valid) begin
        rst_n = 1'b0;
        #1;
        check_eq("abort_tx_valid", 32'(tx_valid), 32'd0);
        check_eq("abort_tx_data", 32'(tx_data), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_led", 32'(led), 32'b111110);
        return;
      end
      if (cyc == 1) begin
        check_eq("arm_busy", 32'(busy), 32'd1);
        check_eq("arm_led", 32'(led), 32'b111101);
      end
      if (stalled) begin
        check_eq("stall_valid", 32'(tx_valid), 32'd1);
        check_eq("stall_data", 32'(tx_data), 32'(stall_data));
      end
      if (cyc % int'(SD) == 0) strobes.push_back(adc_in);
      stalled    = tx_valid && !tx_ready;
      stall_data = tx_data;
      if (tx_valid && tx_ready) begin
        got.push_back(tx_data);
        if (got.size() == DP + 1) done_at = cyc;
      end
      if (cyc == done_at + 1) begin
        check_eq("done_busy", 32'(busy), 32'd1);
        check_eq("done_led", 32'(led), 32'b011111);
        check_eq("done_valid", 32'(tx_valid), 32'd0);
      end
      if (cyc == done_at + 2) begin
        check_eq("idle_busy", 32'(busy), 32'd0);
        check_eq("idle_led", 32'(led), 32'b111110);
        finished = 1'b1;
      end
      @(posedge clk);
      #1;
      if (finished) break;
    end
    start = 1'b0;
    check_eq("frame_finished", 32'(finished), 32'd1);

    t = 0;
`ifdef ADC_STREAM_TRIGGER_EN
    t = -1;
    for (int k = 1; k < strobes.size(); k++) begin
      if (t < 0 && strobes[k-1] < trig_level && strobes[k] >= trig_level) t = k;
    end
    if (t < 0) t = strobes.size();
`endif
    check_eq("byte_count", 32'(got.size()), 32'(DP + 1));
    for (int i = 0; i < got.size(); i++) begin
      idx = t + i - 1;
      if (i == 0)                   exp = 32'(HDR);
      else if (idx < strobes.size()) exp = 32'(strobes[idx]);
      else                          exp = 32'hDEAD;
      check_eq($sformatf("byte%0d", i), 32'(got[i]), exp);
    end
    first_data = (got.size() > 1) ? got[1] : 8'h00;
  endtask

  task automatic expect_idle(input string tag, input int cycles);
    bit bad;
    bad = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (busy || tx_valid) bad = 1'b1;
    end
    check_eq(tag, 32'(bad), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    adc_in     = '0;
    trig_level = '0;
    tx_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_tx_valid", 32'(tx_valid), 32'd0);
    check_eq("rst_tx_data", 32'(tx_data), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_led", 32'(led), 32'b111110);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    tx_ready = 1'b1;
    expect_idle("idle_ready_no_effect", 4);
    tx_ready = 1'b0;

`ifndef ADC_STREAM_TRIGGER_EN
    trig_level = 8'($urandom);
    run_frame(0, 0, 1'b0, 1'b0);
    run_frame(0, 1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      trig_level = 8'($urandom);
      run_frame(1, 2, 1'b0, 1'b0);
    end
    run_frame(0, 0, 1'b1, 1'b0);
    expect_idle("no_second_frame", 3 * int'(SD));
    run_frame(1, 2, 1'b1, 1'b0);
    expect_idle("no_second_frame_rand", 3 * int'(SD));

    run_frame(0, 0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check_eq("abort_hold_valid", 32'(tx_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    expect_idle("abort_no_more_bytes", 10);
    run_frame(0, 0, 1'b0, 1'b0);
    check_eq("fresh_first_data", 32'(first_data), 32'h00);
`else
    trig_level = 8'h80;
    run_frame(2, 0, 1'b0, 1'b0);
    check_eq("trig_first_data", 32'(first_data), 32'h85);
    run_frame(3, 1, 1'b0, 1'b0);
    check_eq("trig_above_at_arm", 32'(first_data), 32'h88);
    for (int i = 0; i < 4; i++) begin
      trig_level = 8'($urandom_range(64, 192));
      run_frame(1, 2, 1'b0, 1'b0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
